// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU op codes, RV32I opcode constants and the issue entry type
package alu_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SUB  = 4'b0001,
      ALU_SLL  = 4'b0010,
      ALU_SLT  = 4'b0011,
      ALU_SLTU = 4'b0100,
      ALU_XOR  = 4'b0101,
      ALU_SRL  = 4'b0110,
      ALU_SRA  = 4'b0111,
      ALU_OR   = 4'b1000,
      ALU_AND  = 4'b1001
   } alu_op_t;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] FUNCT7_ALT = 7'h20;

   // One buffered issue slot: everything the ALU and writeback need.
   typedef struct packed {
      logic [31:0] in1;
      logic [31:0] in2;
      alu_op_t     op;
      logic [4:0]  rd;
      logic        reg_write;
      logic        illegal;
   } alu_entry_t;

   // funct3 -> op; alt selects SUB/SRA in the two slots that have a variant.
   function automatic alu_op_t base_op(input logic [2:0] funct3, input logic alt);
      alu_op_t op;
      case (funct3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/alu_decode.sv
// rtl/alu_decode.sv - combinational RV32I OP/OP-IMM/LUI/AUIPC decode into an issue entry
module alu_decode
   import alu_pkg::*;
(
   input  logic [31:0] instr,
   input  logic [31:0] pc,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   output alu_entry_t  entry
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       ill;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];

   // Select operands and op per opcode; illegal encodings collapse to a harmless ADD 0,0.
   always_comb begin
      entry     = '0;
      entry.op  = ALU_ADD;
      entry.rd  = instr[11:7];
      ill       = 1'b0;
      case (opcode)
         OPC_OP: begin
            entry.in1 = rs1_data;
            entry.in2 = rs2_data;
            if (funct7 == 7'h00)
               entry.op = base_op(funct3, 1'b0);
            else if (funct7 == FUNCT7_ALT && (funct3 == 3'b000 || funct3 == 3'b101))
               entry.op = base_op(funct3, 1'b1);
            else
               ill = 1'b1;
         end
         OPC_OPIMM: begin
            entry.in1 = rs1_data;
            if (funct3 == 3'b001) begin
               entry.in2 = {27'b0, instr[24:20]};
               entry.op  = ALU_SLL;
               ill       = (funct7 != 7'h00);
            end else if (funct3 == 3'b101) begin
               entry.in2 = {27'b0, instr[24:20]};
               if (funct7 == 7'h00)
                  entry.op = ALU_SRL;
               else if (funct7 == FUNCT7_ALT)
                  entry.op = ALU_SRA;
               else
                  ill = 1'b1;
            end else begin
               entry.in2 = {{20{instr[31]}}, instr[31:20]};
               entry.op  = base_op(funct3, 1'b0);
            end
         end
         OPC_LUI: begin
            entry.in2 = {instr[31:12], 12'b0};
         end
         OPC_AUIPC: begin
            entry.in1 = pc;
            entry.in2 = {instr[31:12], 12'b0};
         end
         default: ill = 1'b1;
      endcase
      if (ill) begin
         entry.in1 = '0;
         entry.in2 = '0;
         entry.op  = ALU_ADD;
      end
      entry.illegal   = ill;
      entry.reg_write = !ill && (entry.rd != 5'd0);
   end

endmodule

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - ALU issue stage: decode plus 2-entry skid buffer with valid/ready
module alu_issue
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] instr,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] alu_in1,
   output logic [XLEN-1:0] alu_in2,
   output logic [3:0]      alu_op,
   output logic [4:0]      rd,
   output logic            reg_write,
   output logic            illegal
);

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_TWO   = 2'd2;

   logic [1:0] state_q, state_d;
   alu_entry_t main_q, main_d;
   alu_entry_t skid_q, skid_d;
   logic       in_ready_q, in_ready_d;
   alu_entry_t dec;
   logic       accept;
   logic       consume;

   alu_decode u_decode (
      .instr    (instr),
      .pc       (pc),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data),
      .entry    (dec)
   );

   assign accept  = in_valid && in_ready_q;
   assign consume = (state_q != ST_EMPTY) && out_ready;

   // Skid control: main always holds the oldest entry, skid only fills when main stalls.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  main_d  = dec;
                  state_d = ST_ONE;
               end
            end
            ST_ONE: begin
               if (accept && consume) begin
                  main_d = dec;
               end else if (accept) begin
                  skid_d  = dec;
                  state_d = ST_TWO;
               end else if (consume) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (consume) begin
                  main_d  = skid_q;
                  state_d = ST_ONE;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
      in_ready_d = (state_d != ST_TWO);
   end

   // State and entry registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_EMPTY;
         main_q     <= '0;
         skid_q     <= '0;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
         in_ready_q <= in_ready_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = (state_q != ST_EMPTY);
   assign alu_in1   = main_q.in1;
   assign alu_in2   = main_q.in2;
   assign alu_op    = main_q.op;
   assign rd        = main_q.rd;
   assign reg_write = main_q.reg_write;
   assign illegal   = main_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - directed scoreboard bench for alu_issue
module tb_alu_issue;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr;
   logic [31:0] pc;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] alu_in1;
   logic [31:0] alu_in2;
   logic [3:0]  alu_op;
   logic [4:0]  rd;
   logic        reg_write;
   logic        illegal;

   logic [74:0] obs;
   logic [74:0] exp_cur;
   logic [74:0] sb_q[$];
   int          errors = 0;
   int          checks = 0;

   alu_issue #(.XLEN(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .instr     (instr),
      .pc        (pc),
      .rs1_data  (rs1_data),
      .rs2_data  (rs2_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .alu_in1   (alu_in1),
      .alu_in2   (alu_in2),
      .alu_op    (alu_op),
      .rd        (rd),
      .reg_write (reg_write),
      .illegal   (illegal)
   );

   always #5 clk = ~clk;

   assign obs = {alu_in1, alu_in2, alu_op, rd, reg_write, illegal};

   function automatic logic [74:0] mk(input logic [31:0] i1, input logic [31:0] i2,
                                      input logic [3:0] op, input logic [4:0] d,
                                      input logic rw, input logic ill);
      return {i1, i2, op, d, rw, ill};
   endfunction

   task automatic chk(input string tag, input logic [74:0] got, input logic [74:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask

   // One clock: check output against scoreboard head, record accepted input, advance.
   task automatic cyc();
      @(negedge clk);
      if (out_valid) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_out", 75'(out_valid), 75'(0));
         end else begin
            chk(out_ready ? "pop" : "hold", obs, sb_q[0]);
            if (out_ready) void'(sb_q.pop_front());
         end
      end
      if (flush) sb_q.delete();
      else if (in_valid && in_ready) sb_q.push_back(exp_cur);
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] i, input logic [31:0] p, input logic [31:0] a,
                        input logic [31:0] b, input logic [74:0] e);
      instr    = i;
      pc       = p;
      rs1_data = a;
      rs2_data = b;
      in_valid = 1'b1;
      exp_cur  = e;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      instr = '0; pc = '0; rs1_data = '0; rs2_data = '0; exp_cur = '0;
      #12;
      chk("rst_out_valid", 75'(out_valid), 75'(0));
      chk("rst_in_ready", 75'(in_ready), 75'(1));
      chk("rst_fields", obs, 75'(0));
      rst_n = 1'b1;
      @(posedge clk); #1;

      // latency and decode coverage at full throughput
      out_ready = 1'b1;
      drive(32'h002081B3, 0, 5, 7, mk(5, 7, 4'b0000, 3, 1, 0));
      cyc();
      chk("latency_valid", 75'(out_valid), 75'(1));
      drive(32'h402081B3, 0, 5, 7, mk(5, 7, 4'b0001, 3, 1, 0));                         cyc();
      drive(32'h40435293, 0, 32'h80000000, 0, mk(32'h80000000, 4, 4'b0111, 5, 1, 0));   cyc();
      drive(32'hFFF00093, 0, 32'h11, 0, mk(32'h11, 32'hFFFFFFFF, 4'b0000, 1, 1, 0));     cyc();
      drive(32'h123450B7, 0, 32'h99, 0, mk(0, 32'h12345000, 4'b0000, 1, 1, 0));          cyc();
      drive(32'h00001117, 32'h100, 32'h99, 0, mk(32'h100, 32'h1000, 4'b0000, 2, 1, 0));  cyc();
      drive(32'h022081B3, 0, 5, 7, mk(0, 0, 4'b0000, 3, 0, 1));                         cyc();
      drive(32'h00500013, 0, 3, 0, mk(3, 5, 4'b0000, 0, 0, 0));                         cyc();
      drive(32'h0000006F, 0, 3, 4, mk(0, 0, 4'b0000, 0, 0, 1));                         cyc();
      drive(32'h40109093, 0, 3, 4, mk(0, 0, 4'b0000, 1, 0, 1));                         cyc();
      drive(32'h4020D1B3, 0, 32'hF0000000, 8, mk(32'hF0000000, 8, 4'b0111, 3, 1, 0));   cyc();
      drive(32'h4020C1B3, 0, 1, 2, mk(0, 0, 4'b0000, 3, 0, 1));                         cyc();
      drive(32'hFFE0A213, 0, 9, 0, mk(9, 32'hFFFFFFFE, 4'b0011, 4, 1, 0));               cyc();
      drive(32'h01F35293, 0, 32'hC0DE, 0, mk(32'hC0DE, 31, 4'b0110, 5, 1, 0));           cyc();
      in_valid = 1'b0;
      cyc(); cyc();
      chk("stream_drained", 75'(sb_q.size()), 75'(0));

      // three beats into a stalled consumer, then release
      out_ready = 1'b0;
      drive(32'h002081B3, 0, 1, 2, mk(1, 2, 4'b0000, 3, 1, 0));  cyc();
      chk("one_in_ready", 75'(in_ready), 75'(1));
      drive(32'h402081B3, 0, 9, 4, mk(9, 4, 4'b0001, 3, 1, 0));  cyc();
      chk("two_in_ready", 75'(in_ready), 75'(0));
      drive(32'h00500013, 0, 6, 0, mk(6, 5, 4'b0000, 0, 0, 0));  cyc();
      chk("two_held_ready", 75'(in_ready), 75'(0));
      out_ready = 1'b1;
      cyc();
      chk("drain_valid_1", 75'(out_valid), 75'(1));
      cyc();
      in_valid = 1'b0;
      chk("drain_valid_2", 75'(out_valid), 75'(1));
      cyc();
      chk("skid_drained", 75'(sb_q.size()), 75'(0));
      chk("skid_idle", 75'(out_valid), 75'(0));

      // flush while full; the beat presented with flush is dropped
      out_ready = 1'b0;
      drive(32'h002081B3, 0, 1, 1, mk(1, 1, 4'b0000, 3, 1, 0));  cyc();
      drive(32'h002081B3, 0, 2, 2, mk(2, 2, 4'b0000, 3, 1, 0));  cyc();
      drive(32'h002081B3, 0, 3, 3, mk(3, 3, 4'b0000, 3, 1, 0));
      flush = 1'b1;
      cyc();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_valid", 75'(out_valid), 75'(0));
      chk("flush_ready", 75'(in_ready), 75'(1));

      // flush in the same cycle as a consume
      out_ready = 1'b1;
      drive(32'h00500013, 0, 8, 0, mk(8, 5, 4'b0000, 0, 0, 0));  cyc();
      in_valid = 1'b0; flush = 1'b1;
      cyc();
      flush = 1'b0;
      chk("flush_consume_valid", 75'(out_valid), 75'(0));
      chk("flush_consume_sb", 75'(sb_q.size()), 75'(0));

      // asynchronous reset mid-stream
      out_ready = 1'b0;
      drive(32'h123450B7, 0, 0, 0, mk(0, 32'h12345000, 4'b0000, 1, 1, 0));  cyc();
      drive(32'h002081B3, 0, 4, 4, mk(4, 4, 4'b0000, 3, 1, 0));
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 75'(out_valid), 75'(0));
      chk("arst_in_ready", 75'(in_ready), 75'(1));
      chk("arst_fields", obs, 75'(0));
      sb_q.delete();
      in_valid = 1'b0;
      rst_n = 1'b1;
      cyc();
      chk("post_rst_idle", 75'(out_valid), 75'(0));
      out_ready = 1'b1;
      drive(32'h002081B3, 0, 5, 7, mk(5, 7, 4'b0000, 3, 1, 0));  cyc();
      in_valid = 1'b0;
      cyc();
      chk("final_drained", 75'(sb_q.size()), 75'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
